fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Program-counter register and IF/ID pipeline register of the pipelined MIPS.
//  Drives pc to instruction memory and to the PC+4 adder (A=pc, B=32'd4).
//  Consumes the adder's pc_plus4, picks next PC (sequential/branch/jump), and
//  latches instruction + PC+4 into IF/ID with stall and flush control.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset (word aligned)
//  CNT_W     16             width of saturating flush counter
// PORTS
//  clk            in   1      clock, all state updates on rising edge
//  rst            in   1      synchronous, active-high reset
//  pc_plus4       in   32     pc+4 from external adder (combinational)
//  instr          in   32     imem read data at current pc (combinational)
//  stall          in   1      hazard unit: hold PC and IF/ID
//  branch_taken   in   1      branch resolved taken in ID
//  branch_target  in   32     branch target address
//  jump           in   1      jump in ID
//  jump_target    in   32     jump target address
//  pc             out  32     current PC register
//  if_id_instr    out  32     IF/ID instruction (32'h0 = NOP bubble)
//  if_id_pc_plus4 out  32     IF/ID copy of pc+4
//  if_id_valid    out  1      IF/ID holds a real fetched instruction
//  misalign_err   out  1      sticky: a redirect target had [1:0]!=0
//  flush_count    out  CNT_W  saturating count of redirect flushes
// BEHAVIOUR
//  Reset (rst=1 at edge): pc=RESET_PC, if_id_instr=0, if_id_pc_plus4=0,
//   if_id_valid=0, misalign_err=0, flush_count=0. Overrides all other inputs.
//  redirect = jump | branch_taken; target = jump ? jump_target : branch_target.
//  Per-edge priority (rst=0): redirect > stall > sequential.
//  - redirect: pc <= {target[31:2],2'b00}; IF/ID <= bubble (instr=0,
//    pc_plus4=0, valid=0); flush_count += 1, saturating at 2^CNT_W-1.
//    Redirect wins over simultaneous stall; jump wins over branch.
//  - stall (no redirect): pc, IF/ID, counters all hold their values.
//  - sequential: pc <= pc_plus4; if_id_instr <= instr;
//    if_id_pc_plus4 <= pc_plus4; if_id_valid <= 1.
//  misalign_err set on redirect with target[1:0]!=0; cleared only by rst.
//  Latency: instruction at pc appears on IF/ID one edge after pc presented.
//  Wrap: pc=32'hFFFF_FFFC, pc_plus4=0 -> pc becomes 0 (no error).
//  Reset mid-stall or mid-redirect: reset values win that edge; first
//   post-reset edge is a normal sequential fetch from RESET_PC.
//  pc_plus4 is trusted; the block does not recompute it.
// TESTING
//  1 rst=1 2 cycles, RESET_PC=0 -> pc=0, valid=0, instr=0; release, imem[0]=
//    32'h2008_0005 -> next edge pc=4, if_id_instr=32'h2008_0005, pc_plus4=4, valid=1.
//  2 pc=0x10, stall=1 for 3 edges -> pc=0x10, IF/ID unchanged; stall=0 -> pc=0x14.
//  3 pc=0x20, branch_taken=1, target=0x100 -> pc=0x100, if_id_instr=0,
//    valid=0, flush_count=1; next edge fetch from 0x100, valid=1.
//  4 jump=1 (0x400) + branch_taken=1 (0x100) + stall=1 same edge -> pc=0x400, bubble.
//  5 branch_target=0x102 taken -> pc=0x100, misalign_err=1, stays 1 until rst.
//  6 CNT_W=2, 5 redirects -> flush_count=3; pc=0xFFFF_FFFC seq -> pc=0.

Source files
------------

// File: rtl/fetch_pc_if.sv
// Fetch-stage bus: PC to imem/adder, instruction and pc+4 back, redirect and stall
// control in, IF/ID register contents and status out.
interface fetch_pc_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic [31:0]      instr;
    logic             stall;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic             jump;
    logic [31:0]      jump_target;
    logic [31:0]      if_id_instr;
    logic [31:0]      if_id_pc_plus4;
    logic             if_id_valid;
    logic             misalign_err;
    logic [CNT_W-1:0] flush_count;

    // There is no valid/ready handshake on this bus. Every rising edge without
    // reset either redirects, holds on stall, or accepts instr/pc_plus4 as they
    // stand for the current pc.
    modport master (
        output pc_plus4, instr, stall, branch_taken, branch_target, jump, jump_target,
        input  pc, if_id_instr, if_id_pc_plus4, if_id_valid, misalign_err, flush_count
    );

    modport slave (
        input  pc_plus4, instr, stall, branch_taken, branch_target, jump, jump_target,
        output pc, if_id_instr, if_id_pc_plus4, if_id_valid, misalign_err, flush_count
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and IF/ID pipeline register for the pipelined MIPS fetch stage,
// with redirect (jump/branch), stall hold, misalignment flag and flush counter.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    fetch_pc_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic [31:0]      pc_plus4_q;
    logic             valid_q;
    logic             misalign_q;
    logic [CNT_W-1:0] flush_q;

    logic             redirect;
    logic [31:0]      target;

    // Jump is resolved over branch when both arrive in the same cycle.
    assign redirect = bus.jump | bus.branch_taken;
    assign target   = bus.jump ? bus.jump_target : bus.branch_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            flush_q    <= '0;
        end else if (redirect) begin
            pc_q       <= {target[31:2], 2'b00};
            instr_q    <= 32'h0;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
            if (target[1:0] != 2'b00) begin
                misalign_q <= 1'b1;
            end
            if (flush_q != CNT_MAX) begin
                flush_q <= flush_q + 1'b1;
            end
        end else if (!bus.stall) begin
            pc_q       <= bus.pc_plus4;
            instr_q    <= bus.instr;
            pc_plus4_q <= bus.pc_plus4;
            valid_q    <= 1'b1;
        end
    end

    assign bus.pc             = pc_q;
    assign bus.if_id_instr    = instr_q;
    assign bus.if_id_pc_plus4 = pc_plus4_q;
    assign bus.if_id_valid    = valid_q;
    assign bus.misalign_err   = misalign_q;
    assign bus.flush_count    = flush_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: two instances (default and CNT_W=2 / RESET_PC=0x100)
// share one stimulus stream; a reference model fills expected queues per DUT.
module tb_fetch_pc_unit;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
    logic        mis;
    logic [15:0] cnt;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic jump = 1'b0;
  logic [31:0] jump_target = 32'h0;

  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];
  exp_t ma = '0;
  exp_t mb = '0;
  int checks = 0;
  int errors = 0;

  fetch_pc_if #(.CNT_W(16)) if_a ();
  fetch_pc_if #(.CNT_W(2))  if_b ();

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  fetch_pc_unit #(.RESET_PC(32'h0000_0100), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(if_b));

  // Instruction memory contents: address 0 holds 32'h2008_0005.
  function automatic logic [31:0] imem(input logic [31:0] addr);
    return (addr * 32'h9E37_79B9) ^ 32'h2008_0005;
  endfunction

  assign if_a.pc_plus4 = if_a.pc + 32'd4;
  assign if_a.instr = imem(if_a.pc);
  assign if_a.stall = stall;
  assign if_a.branch_taken = branch_taken;
  assign if_a.branch_target = branch_target;
  assign if_a.jump = jump;
  assign if_a.jump_target = jump_target;

  assign if_b.pc_plus4 = if_b.pc + 32'd4;
  assign if_b.instr = imem(if_b.pc);
  assign if_b.stall = stall;
  assign if_b.branch_taken = branch_taken;
  assign if_b.branch_target = branch_target;
  assign if_b.jump = jump;
  assign if_b.jump_target = jump_target;

  // clock
  always #5 clk = ~clk;

  // Reference model: what the fetch stage should hold after one edge.
  function automatic exp_t step(input exp_t s, input logic r, input logic st,
                                input logic br, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt,
                                input logic [31:0] rpc, input int unsigned cmax);
    exp_t n;
    logic [31:0] tgt;
    n = s;
    if (r) begin
      n = '0;
      n.pc = rpc;
    end else if (j || br) begin
      tgt = j ? jt : bt;
      n.pc = (tgt / 4) * 4;
      n.instr = 32'h0;
      n.pp4 = 32'h0;
      n.valid = 1'b0;
      if (tgt % 4 != 0) n.mis = 1'b1;
      if (int'(n.cnt) < int'(cmax)) n.cnt = n.cnt + 16'd1;
    end else if (!st) begin
      n.instr = imem(s.pc);
      n.pp4 = s.pc + 32'd4;
      n.pc = s.pc + 32'd4;
      n.valid = 1'b1;
    end
    return n;
  endfunction

  // driver: one edge's worth of inputs plus expected results
  task automatic drive(input logic r, input logic st, input logic br,
                       input logic [31:0] bt, input logic j, input logic [31:0] jt);
    @(negedge clk);
    rst = r;
    stall = st;
    branch_taken = br;
    branch_target = bt;
    jump = j;
    jump_target = jt;
    ma = step(ma, r, st, br, bt, j, jt, 32'h0000_0000, 65535);
    mb = step(mb, r, st, br, bt, j, jt, 32'h0000_0100, 3);
    exp_a_q.push_back(ma);
    exp_b_q.push_back(mb);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_a_q.size() > 0) begin
      e = exp_t'(exp_a_q.pop_front());
      cmp("a_pc", if_a.pc, e.pc);
      cmp("a_if_id_instr", if_a.if_id_instr, e.instr);
      cmp("a_if_id_pc_plus4", if_a.if_id_pc_plus4, e.pp4);
      cmp("a_if_id_valid", {31'h0, if_a.if_id_valid}, {31'h0, e.valid});
      cmp("a_misalign_err", {31'h0, if_a.misalign_err}, {31'h0, e.mis});
      cmp("a_flush_count", {16'h0, if_a.flush_count}, {16'h0, e.cnt});
    end
    if (exp_b_q.size() > 0) begin
      e = exp_t'(exp_b_q.pop_front());
      cmp("b_pc", if_b.pc, e.pc);
      cmp("b_if_id_instr", if_b.if_id_instr, e.instr);
      cmp("b_if_id_pc_plus4", if_b.if_id_pc_plus4, e.pp4);
      cmp("b_if_id_valid", {31'h0, if_b.if_id_valid}, {31'h0, e.valid});
      cmp("b_misalign_err", {31'h0, if_b.misalign_err}, {31'h0, e.mis});
      cmp("b_flush_count", {30'h0, if_b.flush_count}, {16'h0, e.cnt});
    end
  end

  initial begin
    logic [31:0] bt;
    logic [31:0] jt;
    int r;
    // reset for two edges, then first fetch from RESET_PC
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    seq(4);
    // stall three edges at pc=0x10, then resume
    repeat (3) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    seq(4);
    // branch taken to 0x100, then fetch from there
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    seq(2);
    // jump + branch + stall together: jump wins
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0400);
    seq(1);
    // misaligned branch target
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0);
    seq(2);
    // more redirects to saturate the narrow counter
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0200);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    // wrap from the top of the address space
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    seq(2);
    // reset during stall and redirect, then normal fetch
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0102, 1'b1, 32'h0000_0801);
    seq(2);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      bt = $urandom();
      jt = $urandom();
      if ($urandom_range(0, 1) == 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) jt[1:0] = 2'b00;
      drive(r < 2, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, bt,
            $urandom_range(0, 9) == 0, jt);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    seq(2);
    // drain, bounded
    for (int i = 0; i < 10 && (exp_a_q.size() > 0 || exp_b_q.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_a_q.size() > 0 || exp_b_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0", exp_a_q.size(), exp_b_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
